mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-master arbiter that shares the single data-memory/MMIO port between the CPU data interface (m0) and a second requester (m1, DMA or debug loader). It sits between the requesters and the memory-map decoder, whose address, write data, write strobe and read data it drives and samples. Only one transaction is in flight at a time. The MMIO write strobe is asserted for exactly one cycle per write, so peripheral `_we` side effects (LED, 7-seg, timer, temp control) fire once.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `RD_LAT`, 1, cycles from address presented to `bus_rdata` valid; legal range 1..7

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `m0_req`, `m1_req`  in  1  request; hold high with `we`/`addr`/`wdata` stable until ack
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  AW  byte address
- `m0_wdata`, `m1_wdata`  in  DW  write data
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `m0_rdata`, `m1_rdata`  out  DW  read data, valid when ack is high, held until that master's next read completes
- `bus_addr`  out  AW  to decoder address
- `bus_wdata`  out  DW  to decoder write data
- `bus_we`  out  1  to decoder write strobe
- `bus_rdata`  in  DW  from decoder read data
- `busy`  out  1  high when state ≠ IDLE
- `owner`  out  1  master of the current or last transaction

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE.** At each edge, if any `req` is high:
  - pick a winner;
  - latch its `addr`, `wdata` and `we` into bus registers;
  - set `owner`;
  - load `cnt = RD_LAT`;
  - go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS.**
  - `bus_addr` and `bus_wdata` are driven from the latched registers.
  - `bus_we` equals the latched `we` in the first ACCESS cycle only, and is 0 in later ACCESS cycles.
  - `cnt` decrements at each edge.
  - At the edge where `cnt == 1`:
    - for a read, capture `bus_rdata` into the owner's `rdata`;
    - go to RESP.
- **RESP.** The owner's `ack` is 1 for this single cycle. Go to IDLE at the next edge.
- **Arbitration.**
  - Only one request: that master wins.
  - Both requesting: the winner is set by the configuration macro.
- **Writes.** Writes never update `mX_rdata`. Writes are acked with the same timing as reads.
- **Non-owner.** The non-owner's `ack` is 0 at all times. The non-owner's `req` is ignored until IDLE.
- **Request dropped early.** A master that drops `req` before ack does not abort the transaction; the transaction still completes and acks.
- **No decoding.** The block does no address decoding. Unmapped addresses pass through, and whatever the decoder returns (0) is captured.
- **Request held after ack.** A master whose `req` is still high in the IDLE cycle after its ack is treated as issuing a new transaction.

## Timing
- Request sampled at edge k:
  - ACCESS occupies cycles k..k+RD_LAT−1.
  - RESP (ack high) is cycle k+RD_LAT.
  - IDLE is cycle k+RD_LAT+1.
- The next arbitration happens at edge k+RD_LAT+2.
- Minimum transaction period is RD_LAT+2 cycles; RD_LAT=1 gives 3 cycles.
- `bus_we` high for exactly 1 cycle per write, in cycle k.
- `bus_addr`/`bus_wdata` are held from edge k until the next grant; they are not cleared in IDLE.
- Reset values (`rst_n` low at an edge):
  - state = IDLE;
  - `bus_addr`, `bus_wdata`, `m0_rdata`, `m1_rdata` = 0;
  - `bus_we`, `m0_ack`, `m1_ack`, `busy` = 0;
  - `owner` = 1, so m0 wins the first tie under round-robin;
  - `cnt` = 0.
- **Reset mid-transaction.** The transaction is abandoned with no ack. `bus_we` is 0 from the next cycle. A write whose strobe cycle was already issued is not undone.
- `rst_n` is sampled only at `clk` edges. Outputs change only on edges.

## Configuration
- `MEMARB_RR_EN` defined: round-robin on ties. The master that is not `owner` wins, and `owner` updates on every grant.
- `MEMARB_RR_EN` undefined: fixed priority on ties, m0 always wins. m1 is served only in IDLE cycles where `m0_req` is low. All other behaviour is identical.

## Test plan
1. **m0 write.** Stimulus: RD_LAT=1; m0 writes `addr=0x0000_1000`, `wdata=0x1234_5678`. Required: `bus_we=1` for exactly one cycle with `bus_addr=0x1000` and `bus_wdata=0x12345678`; `m0_ack` one cycle later; `m1_ack` stays 0.
2. **m1 read.** Stimulus: m1 reads `0x0000_2000` with `bus_rdata=0xBBBB_BBBB`. Required: `m1_rdata=0xBBBBBBBB` in the ack cycle and held afterwards; `bus_we` stays 0; `m0_rdata` unchanged.
3. **Ties, round-robin.** Stimulus: with `MEMARB_RR_EN`, both masters request continuously from reset. Required: grants in order m0, m1, m0, m1; acks spaced 3 cycles apart.
4. **Ties, fixed priority.** Stimulus: without the macro, same stimulus as scenario 3. Required: only m0 is acked. m1 is acked in the first transaction after `m0_req` is dropped.
5. **Longer latency.** Stimulus: RD_LAT=3; m0 reads `0x201C` with `bus_rdata` changing from `0x0` to `0xCCCC_CCCC` two cycles after grant. Required: `m0_rdata=0xCCCCCCCC`; ack at cycle k+3; `bus_we` never high.
6. **Reset mid-operation.** Stimulus: `rst_n` low during ACCESS of an m1 write. Required: no `m1_ack`; state IDLE; all outputs at reset values the next cycle; after reset, the first tie goes to m0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one memory/MMIO port; one transaction in flight.
// Define MEMARB_RR_EN for round-robin on ties; otherwise m0 has fixed priority.
module mem_bus_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_we,
    input  logic [DW-1:0] bus_rdata,
    output logic          busy,
    output logic          owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] LP_LAT = 3'(RD_LAT);

    state_t        r_state, w_next;
    logic [2:0]    r_cnt;
    logic          r_owner, r_we_lat, r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata, r_m0_rdata, r_m1_rdata;
    logic          w_grant, w_win, w_done;

    // w_win: 0 selects m0, 1 selects m1
    always_comb begin
        w_win = m1_req & ~m0_req;
`ifdef MEMARB_RR_EN
        if (m0_req && m1_req) w_win = ~r_owner;
`else
        if (m0_req && m1_req) w_win = 1'b0;
`endif
    end

    assign w_grant = (r_state == IDLE) && (m0_req || m1_req);
    assign w_done  = (r_state == ACCESS) && (r_cnt == 3'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next = ACCESS;
            ACCESS:  if (w_done)  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobe defaults low so it lives only in the first ACCESS cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner     <= 1'b1;
            r_we_lat    <= 1'b0;
            r_bus_we    <= 1'b0;
            r_cnt       <= 3'd0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_bus_we <= 1'b0;
            if (w_grant) begin
                r_owner     <= w_win;
                r_bus_addr  <= w_win ? m1_addr  : m0_addr;
                r_bus_wdata <= w_win ? m1_wdata : m0_wdata;
                r_we_lat    <= w_win ? m1_we    : m0_we;
                r_bus_we    <= w_win ? m1_we    : m0_we;
                r_cnt       <= LP_LAT;
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt - 3'd1;
                if (w_done && !r_we_lat) begin
                    if (r_owner) r_m1_rdata <= bus_rdata;
                    else         r_m0_rdata <= bus_rdata;
                end
            end
        end
    end

    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_we    = r_bus_we;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign owner     = r_owner;
    assign busy      = (r_state != IDLE);
    assign m0_ack    = (r_state == RESP) && !r_owner;
    assign m1_ack    = (r_state == RESP) &&  r_owner;
endmodule
